seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: eight-digit multiplexed seven-segment scan controller.
//
// Cycles through eight digit slots of CLK_DIV clocks each. Each slot starts
// with GUARD anode-off cycles so that the outgoing digit's segments are not
// smeared onto the next one. New display data is double-buffered and only
// committed at a frame boundary, so a frame never shows a mix of old and new
// values.
//
// Ports
//   i_clk          single clock, all state changes on the rising edge
//   i_reset        asynchronous, active-high reset
//   i_data[31:0]   eight hex nibbles, nibble k = i_data[4k+3:4k], digit 0 rightmost
//   i_load         capture request for i_data, sampled on the clock edge
//   i_enable       1 = scanning runs, 0 = scan frozen and all digits dark
//   o_store[3:0]   nibble of the current slot, to the segment decoder
//   o_led_reset    active-low reset to the segment decoder
//   o_an[7:0]      active-low digit anodes, o_an[k] drives digit k
//   o_frame_done   one-cycle pulse after the last slot of each frame
//
// Parameters
//   CLK_DIV   clock cycles per digit slot (4..65535)
//   GUARD     anode-off cycles at the start of each slot (0..CLK_DIV-2)
//   BLANK_LZ  1 enables leading-zero blanking

module seg_scan #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned GUARD    = 2,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_data,
  input  logic        i_load,
  input  logic        i_enable,
  output logic [3:0]  o_store,
  output logic        o_led_reset,
  output logic [7:0]  o_an,
  output logic        o_frame_done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned AN_W   = 8;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

  // Registered state
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_disp;
  logic [DATA_W-1:0] r_pend;
  logic              r_pend_valid;

  // Registered outputs
  logic [NIB_W-1:0]  r_store;
  logic [AN_W-1:0]   r_an;
  logic              r_frame_done;
  logic              r_led_reset;

  // Next-state values
  logic              w_tick;
  logic              w_frame_end;
  logic [CNT_W-1:0]  w_count_n;
  logic [IDX_W-1:0]  w_idx_n;
  logic [DATA_W-1:0] w_disp_n;
  logic [DATA_W-1:0] w_pend_n;
  logic              w_pend_valid_n;
  logic [4:0]        w_nib_base;
  logic              w_blank_n;
  logic [NIB_W-1:0]  w_store_n;
  logic [AN_W-1:0]   w_an_n;

  // Prescaler tick and frame boundary
  assign w_tick      = i_enable && (r_count == CNT_LAST);
  assign w_frame_end = w_tick && (r_idx == IDX_LAST);

  // Prescaler and digit index; both hold while scanning is disabled
  always_comb begin
    w_count_n = r_count;
    w_idx_n   = r_idx;
    if (w_tick) begin
      w_count_n = '0;
      w_idx_n   = r_idx + IDX_W'(1);
    end else if (i_enable) begin
      w_count_n = r_count + CNT_W'(1);
    end
  end

  // Display double buffer. A load bypasses the pending register whenever the
  // display can change without tearing: scan frozen, or on the frame boundary.
  always_comb begin
    w_disp_n       = r_disp;
    w_pend_n       = r_pend;
    w_pend_valid_n = r_pend_valid;
    if (i_load) begin
      w_pend_n = i_data;
      if (!i_enable || w_frame_end) begin
        w_disp_n       = i_data;
        w_pend_valid_n = 1'b0;
      end else begin
        w_pend_valid_n = 1'b1;
      end
    end else if (w_frame_end && r_pend_valid) begin
      w_disp_n       = r_pend;
      w_pend_valid_n = 1'b0;
    end
  end

  // Nibble selection and leading-zero detection for the slot being entered;
  // a digit is blank when it and every digit to its left are zero.
  assign w_nib_base = {w_idx_n, 2'b00};
  assign w_store_n  = w_disp_n[w_nib_base +: NIB_W];
  assign w_blank_n  = BLANK_LZ && (w_idx_n != '0) && ((w_disp_n >> w_nib_base) == '0);

  // Anode drive for the slot being entered
  always_comb begin
    w_an_n = '1;
    if (i_enable && (w_count_n >= GUARD_CNT) && !w_blank_n) begin
      w_an_n[w_idx_n] = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count      <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_store      <= '0;
      r_an         <= '1;
      r_frame_done <= 1'b0;
      r_led_reset  <= 1'b0;
    end else begin
      r_count      <= w_count_n;
      r_idx        <= w_idx_n;
      r_disp       <= w_disp_n;
      r_pend       <= w_pend_n;
      r_pend_valid <= w_pend_valid_n;
      r_store      <= w_store_n;
      r_an         <= w_an_n;
      r_frame_done <= w_frame_end;
      r_led_reset  <= 1'b1;
    end
  end

  assign o_store      = r_store;
  assign o_an         = r_an;
  assign o_frame_done = r_frame_done;
  assign o_led_reset  = r_led_reset;

endmodule
